// File: rtl/div3_stream_ctrl.sv
// Streaming divisible-by-3 checker: consumes an operand MS chunk first and reports rem==0.
// Optional rem_out port is enabled by defining DIV3_REM_OUT_EN.
module div3_stream_ctrl #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SIZE-1:0]                    digit,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out,
  output logic                               out_trunc,
`ifdef DIV3_REM_OUT_EN
  output logic [$clog2(MAX_WORDS+1)-1:0]     out_words,
  output logic [1:0]                         rem_out
`else
  output logic [$clog2(MAX_WORDS+1)-1:0]     out_words
`endif
);

  localparam int unsigned    CW   = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]  MAXC = CW'(MAX_WORDS);
  localparam bit             K2   = (SIZE % 2) == 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      rem, rem_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            trunc, trunc_nxt;

  logic [1:0]      dres;
  logic [1:0]      rem_base;
  logic [1:0]      rem_k;
  logic [CW-1:0]   cnt_inc;
  logic            accept;

  function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // 2^i mod 3 alternates 1,2,1,2... so each set bit adds 1 or 2 to the residue
  function automatic logic [1:0] residue(input logic [SIZE-1:0] d);
    logic [1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (d[i]) acc = add3(acc, i[0] ? 2'd2 : 2'd1);
    end
    return acc;
  endfunction

  always_comb begin
    dres     = residue(digit);
    rem_base = (state == IDLE) ? 2'd0 : rem;
    rem_k    = rem_base;
    // 2^SIZE mod 3 is 2 for odd SIZE: doubling mod 3 swaps residues 1 and 2
    if (K2) begin
      case (rem_base)
        2'd1:    rem_k = 2'd2;
        2'd2:    rem_k = 2'd1;
        default: rem_k = 2'd0;
      endcase
    end
    cnt_inc  = ((state == IDLE) ? '0 : cnt) + CW'(1);
    in_ready = (state != DONE);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    cnt_nxt   = cnt;
    trunc_nxt = trunc;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          rem_nxt = add3(rem_k, dres);
          cnt_nxt = cnt_inc;
          if (in_last) begin
            state_nxt = DONE;
            trunc_nxt = 1'b0;
          end else if (cnt_inc == MAXC) begin
            state_nxt = DONE;
            trunc_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
            trunc_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
    out       = out_valid && (rem == 2'd0);
    out_trunc = out_valid && trunc;
    out_words = out_valid ? cnt : '0;
`ifdef DIV3_REM_OUT_EN
    rem_out   = out_valid ? rem : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt_nxt;
      trunc <= trunc_nxt;
    end
  end

endmodule

// File: tb/tb_div3_stream_ctrl.sv
// Bench for div3_stream_ctrl: three instances (SIZE=8/16 words, SIZE=5/4 words, SIZE=8/2 words)
// checked against an arithmetic operand-mod-3 model.
module tb_div3_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d0, d2;
  logic [4:0] d1;
  logic [2:0] iv, il, ordy, irdy, ov, o, ot;
  logic [4:0] ow0;
  logic [2:0] ow1;
  logic [1:0] ow2;
`ifdef DIV3_REM_OUT_EN
  logic [1:0] r0, r1, r2;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned sizes [3] = '{8, 5, 8};
  int unsigned wq [$];

  div3_stream_ctrl #(.SIZE(8), .MAX_WORDS(16)) u0 (
    .clk(clk), .rst_n(rst_n), .digit(d0), .in_valid(iv[0]), .in_last(il[0]),
    .in_ready(irdy[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(o[0]),
    .out_trunc(ot[0]),
`ifdef DIV3_REM_OUT_EN
    .rem_out(r0),
`endif
    .out_words(ow0)
  );

  div3_stream_ctrl #(.SIZE(5), .MAX_WORDS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .digit(d1), .in_valid(iv[1]), .in_last(il[1]),
    .in_ready(irdy[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(o[1]),
    .out_trunc(ot[1]),
`ifdef DIV3_REM_OUT_EN
    .rem_out(r1),
`endif
    .out_words(ow1)
  );

  div3_stream_ctrl #(.SIZE(8), .MAX_WORDS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .digit(d2), .in_valid(iv[2]), .in_last(il[2]),
    .in_ready(irdy[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out(o[2]),
    .out_trunc(ot[2]),
`ifdef DIV3_REM_OUT_EN
    .rem_out(r2),
`endif
    .out_words(ow2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
  endtask

  function automatic logic [31:0] get_ow(input int s);
    case (s)
      0:       return 32'(ow0);
      1:       return 32'(ow1);
      default: return 32'(ow2);
    endcase
  endfunction

  task automatic drive(input int s, input int unsigned d, input logic v, input logic l);
    case (s)
      0:       d0 = d[7:0];
      1:       d1 = d[4:0];
      default: d2 = d[7:0];
    endcase
    iv[s] = v;
    il[s] = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one chunk and wait (bounded) until it is accepted
  task automatic send_word(input int s, input int unsigned d, input logic last);
    int n;
    n = 0;
    drive(s, d, 1'b1, last);
    while (irdy[s] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    tick();
    drive(s, 0, 1'b0, 1'b0);
  endtask

  // Value of the whole operand mod 3, from chunk values and chunk width
  function automatic int unsigned ref_rem(input int s);
    int unsigned r;
    r = 0;
    foreach (wq[i]) r = (r * (32'd1 << sizes[s]) + wq[i]) % 3;
    return r;
  endfunction

  task automatic check_res(input int s, input int unsigned words, input logic trunc,
                           input int unsigned r);
    check("out_valid", ov[s], 1);
    check("out", o[s], (r == 0) ? 1 : 0);
    check("out_trunc", ot[s], trunc);
    check("out_words", get_ow(s), words);
`ifdef DIV3_REM_OUT_EN
    case (s)
      0:       check("rem_out", r0, r);
      1:       check("rem_out", r1, r);
      default: check("rem_out", r2, r);
    endcase
`endif
  endtask

  task automatic take(input int s);
    ordy[s] = 1'b1;
    tick();
    ordy[s] = 1'b0;
    check("valid_drop", ov[s], 0);
    check("ready_back", irdy[s], 1);
    check("out_idle", o[s], 0);
  endtask

  task automatic send_queue(input int s);
    foreach (wq[i]) begin
      send_word(s, wq[i], i == wq.size() - 1);
      if (i != wq.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    int unsigned n, r;
    rst_n = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    iv = '0; il = '0; ordy = '0;
    #3;
    for (int s = 0; s < 3; s++) begin
      check("rst_valid", ov[s], 0);
      check("rst_out", o[s], 0);
      check("rst_trunc", ot[s], 0);
      check("rst_words", get_ow(s), 0);
    end
    tick();
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", irdy, 3'b111);

    // Single chunk 9
    wq = '{9};
    send_queue(0);
    check_res(0, 1, 1'b0, 0);
    take(0);

    // 256 then 258
    wq = '{1, 0};
    send_queue(0);
    check_res(0, 2, 1'b0, ref_rem(0));
    check("rem_256", ref_rem(0), 1);
    take(0);
    wq = '{1, 2};
    send_queue(0);
    check_res(0, 2, 1'b0, 0);
    take(0);

    // SIZE=5: 33 is divisible by 3
    wq = '{1, 1};
    send_queue(1);
    check_res(1, 2, 1'b0, 0);
    take(1);

    // Consumer stall for 5 cycles
    wq = '{7, 200, 13};
    send_queue(0);
    r = ref_rem(0);
    drive(0, 5, 1'b1, 1'b1);
    repeat (5) begin
      tick();
      check_res(0, 3, 1'b0, r);
      check("stall_rdy", irdy[0], 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    take(0);

    // MAX_WORDS=2 truncation, third chunk stalls then starts the next operand
    send_word(2, 8'h10, 1'b0);
    send_word(2, 8'h22, 1'b0);
    wq = '{8'h10, 8'h22};
    check_res(2, 2, 1'b1, ref_rem(2));
    drive(2, 8'h33, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      check("trunc_stall", irdy[2], 0);
      check("trunc_hold", ov[2], 1);
    end
    take(2);
    send_word(2, 8'h33, 1'b0);
    send_word(2, 8'h04, 1'b1);
    wq = '{8'h33, 8'h04};
    check_res(2, 2, 1'b0, ref_rem(2));
    take(2);

    // Asynchronous reset mid-operand (u0) and in DONE (u1)
    send_word(1, 3, 1'b1);
    check("pre_rst_done", ov[1], 1);
    send_word(0, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ov, 0);
    check("arst_out", o, 0);
    check("arst_trunc", ot, 0);
    check("arst_words0", get_ow(0), 0);
    check("arst_words1", get_ow(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_after_arst", irdy, 3'b111);
    tick();
    wq = '{3};
    send_queue(0);
    check_res(0, 1, 1'b0, 0);
    take(0);

    // Randomized operands on every instance
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 6; k++) begin
        n = (s == 0) ? $urandom_range(1, 6) : ((s == 1) ? $urandom_range(1, 4) : $urandom_range(1, 2));
        wq = {};
        for (int unsigned j = 0; j < n; j++) wq.push_back($urandom_range(0, (1 << sizes[s]) - 1));
        send_queue(s);
        check_res(s, n, 1'b0, ref_rem(s));
        take(s);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div3_stream_ctrl.md
DIV3_STREAM_CTRL -- requirements
Module: div3_stream_ctrl

Interface
REQ-001 The module SHALL have parameter SIZE, default 8, giving the chunk width in bits (SIZE >= 2).
REQ-002 The module SHALL have parameter MAX_WORDS, default 16, giving the maximum chunks per operand (MAX_WORDS >= 1).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port digit, input, SIZE bits, the current operand chunk, most significant chunk first.
REQ-006 The module SHALL have port in_valid, input, 1 bit, meaning digit and in_last are valid.
REQ-007 The module SHALL have port in_last, input, 1 bit, marking the final chunk of the operand.
REQ-008 The module SHALL have port in_ready, output, 1 bit, meaning the block accepts a chunk this cycle.
REQ-009 The module SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 The module SHALL have port out, output, 1 bit, which is 1 when the whole operand is divisible by 3.
REQ-012 The module SHALL have port out_trunc, output, 1 bit, which is 1 when the operand was cut off at MAX_WORDS.
REQ-013 The module SHALL have port out_words, output, $clog2(MAX_WORDS+1) bits, giving the number of chunks consumed.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE; both IDLE and ACCUM accept chunks.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; a chunk is accepted when in_valid and in_ready are both 1.
REQ-016 The chunk residue SHALL be computed combinationally as digit mod 3, with no extra latency.
REQ-017 On an accepted chunk, the remainder SHALL update as rem <= (rem*K + digit mod 3) mod 3, where K=1 for even SIZE and K=2 for odd SIZE.
REQ-018 The rem register SHALL be 2 bits wide and SHALL never hold the value 3.
REQ-019 A chunk accepted in IDLE SHALL start a new operand, using rem=0 and word count=0 before the update.
REQ-020 When the accepted chunk has in_last=0 and the count after the update is below MAX_WORDS, the FSM SHALL go to ACCUM.
REQ-021 When the accepted chunk has in_last=1, the FSM SHALL go to DONE, and out_valid SHALL be 1 in the next cycle.
REQ-022 When the accepted chunk has in_last=0 but the count reaches MAX_WORDS, the FSM SHALL go to DONE with out_trunc=1.
REQ-023 In DONE, out SHALL equal (rem==0), out_words SHALL equal the count, and all three SHALL stay stable while out_valid=1.
REQ-024 In DONE with out_ready=1, the FSM SHALL go to IDLE and out_valid SHALL drop the next cycle; throughput is one operand per (words+1) cycles minimum.
REQ-025 In DONE with out_ready=0, the FSM SHALL hold indefinitely and accept no input.
REQ-026 When in_valid=0 in ACCUM, the FSM SHALL hold its state, rem and count unchanged.
REQ-027 out and out_trunc SHALL be meaningful only while out_valid=1, and SHALL be driven to 0 in IDLE and ACCUM.

Reset
REQ-028 While rst_n=0, the module SHALL immediately force the state to IDLE, rem=0, count=0, out_valid=0, out=0, out_trunc=0 and out_words=0.
REQ-029 A reset asserted mid-operand or in DONE SHALL discard the partial result, with no output produced for it.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Configuration
REQ-031 When macro DIV3_REM_OUT_EN is defined, the module SHALL add output port rem_out, 2 bits, equal to the final remainder (0..2) while out_valid=1 and 0 otherwise.
REQ-032 When DIV3_REM_OUT_EN is not defined, the module SHALL have no rem_out port, and all other behaviour SHALL be identical.

Verification
REQ-033 With SIZE=8, the single chunk 0x09 with last -> out_valid next cycle, out=1, out_words=1, rem_out=0.
REQ-034 With SIZE=8, chunks 0x01 then 0x00 with last (256) -> out=0, rem_out=1; chunks 0x01 then 0x02 (258) -> out=1.
REQ-035 With SIZE=5, chunks 0x01 then 0x01 with last (33) -> out=1, rem_out=0, confirming K=2.
REQ-036 With out_ready=0 held for 5 cycles in DONE -> out_valid, out and out_words stay stable and in_ready=0; releasing it -> IDLE one cycle later.
REQ-037 With MAX_WORDS=2, three chunks sent without last -> DONE after the 2nd chunk, out_trunc=1, out_words=2, and the 3rd chunk stalls until the result is taken.
REQ-038 Asserting rst_n=0 after the 1st of 3 chunks -> all outputs 0 asynchronously; a following fresh operand 0x03 with last -> out=1, out_words=1.
